axis_packetizer: RTL and testbench



---
 rtl/axis_packetizer_pkg.sv | 16 +
 rtl/axis_packetizer_if.sv | 23 ++
 rtl/axis_skid_buffer.sv | 47 ++++
 rtl/axis_packetizer.sv | 102 ++++++++++
 tb/tb_axis_packetizer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_packetizer_pkg.sv
// Shared types and helpers for the AXI4-Stream packetizer.
// Imported by the packetizer top and its skid buffer.
package axis_packetizer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STS_WIDTH = 32;

    function automatic logic [31:0] len_clamp(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/axis_packetizer_if.sv
// AXI4-Stream bundle with master/slave modports.
// The slave side carries no tlast; the master side does.
interface axis_packetizer_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [W-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: output register plus one overflow slot.
// in_ready comes straight from a flop, never from out_ready.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  take;

    assign in_ready = ~skid_valid;
    assign take     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (take) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (take) begin
            // output stalled: park the beat so out_* stay stable
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Cuts a free-running AXI4-Stream into fixed-length tlast-framed packets.
// Optional AXIS_PACKETIZER_DROP_CNT_EN: drain and count beats while idle.
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_enable,
    input  logic [CNTR_WIDTH-1:0] cfg_length,
    axis_packetizer_if.slave      S_AXIS,
    axis_packetizer_if.master     M_AXIS,
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    output logic [STS_WIDTH-1:0]  sts_dropped,
`endif
    output logic [STS_WIDTH-1:0]  sts_packets
);

    state_t                  state;
    logic [CNTR_WIDTH-1:0]   len;
    logic [CNTR_WIDTH-1:0]   cnt;
    logic                    run;
    logic                    buf_ready;
    logic                    accept;
    logic                    last_beat;
    logic                    pkt_done;
    logic [CNTR_WIDTH-1:0]   new_len;
    logic [AXIS_TDATA_WIDTH:0] buf_out;

    assign run       = (state == RUN);
    assign accept    = S_AXIS.tvalid & S_AXIS.tready;
    assign last_beat = (cnt == len - 1'b1);
    assign new_len   = CNTR_WIDTH'(len_clamp(32'(cfg_length)));
    assign pkt_done  = M_AXIS.tvalid & M_AXIS.tready & M_AXIS.tlast;

`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    assign S_AXIS.tready = run ? buf_ready : 1'b1;
`else
    assign S_AXIS.tready = run & buf_ready;
`endif

    axis_skid_buffer #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH + 1)
    ) u_skid (
        .clk      (aclk),
        .rst_n    (aresetn),
        .in_valid (S_AXIS.tvalid & run),
        .in_ready (buf_ready),
        .in_data  ({last_beat, S_AXIS.tdata}),
        .out_valid(M_AXIS.tvalid),
        .out_ready(M_AXIS.tready),
        .out_data (buf_out)
    );

    assign M_AXIS.tlast = buf_out[AXIS_TDATA_WIDTH];
    assign M_AXIS.tdata = buf_out[AXIS_TDATA_WIDTH-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        len   <= new_len;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            cnt <= '0;
                            if (cfg_enable) len <= new_len;
                            else            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sts_packets <= '0;
        else if (pkt_done) sts_packets <= sts_packets + 1'b1;
    end

`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sts_dropped <= '0;
        else if (accept && !run) sts_dropped <= sts_dropped + 1'b1;
    end
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: expected beats queued up front,
// observed master beats queued by a monitor, compared per scenario.
module tb_axis_packetizer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_length = 16'd0;
    logic [31:0] sts_packets;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    logic [31:0] sts_dropped;
`endif

    axis_packetizer_if #(.W(32)) s_if ();
    axis_packetizer_if #(.W(32)) m_if ();

    always #5 aclk = ~aclk;

    axis_packetizer #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH      (16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cfg_enable (cfg_enable),
        .cfg_length (cfg_length),
        .S_AXIS     (s_if.slave),
        .M_AXIS     (m_if.master),
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
        .sts_dropped(sts_dropped),
`endif
        .sts_packets(sts_packets)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_vld = -1;
    int stab_err = 0;
    logic        hold_v = 1'b0;
    logic [32:0] hold_d = '0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    always @(posedge aclk) cyc <= cyc + 1;

    // handshakes seen at the negedge complete on the following posedge
    always @(negedge aclk) begin
        if (!aresetn) begin
            hold_v = 1'b0;
        end else begin
            if (m_if.tvalid && m_if.tready)
                obs_q.push_back({m_if.tlast, m_if.tdata});
            if (m_if.tvalid && first_vld < 0) first_vld = cyc;
            if (s_if.tvalid && s_if.tready && first_acc < 0) first_acc = cyc;
            if (hold_v && (!m_if.tvalid || {m_if.tlast, m_if.tdata} !== hold_d))
                stab_err++;
            hold_v = m_if.tvalid && !m_if.tready;
            hold_d = {m_if.tlast, m_if.tdata};
        end
    end

    task automatic do_reset;
        aresetn = 1'b0;
        cfg_enable = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        first_acc = -1;
        first_vld = -1;
        stab_err = 0;
    endtask

    task automatic enable(input int len);
        cfg_length = 16'(len);
        cfg_enable = 1'b1;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic stream(input int n, input int d0, input bit rnd,
                          input int dis_at, input int len_at,
                          input int nlen, output int sent);
        int  guard;
        bit  acc;
        guard = 0;
        sent = 0;
        s_if.tdata = 32'(d0);
        s_if.tvalid = 1'b1;
        while (sent < n && guard < 20000) begin
            if (rnd) m_if.tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            acc = s_if.tvalid && s_if.tready;
            @(posedge aclk);
            #1;
            if (acc) begin
                sent++;
                s_if.tdata = 32'(d0 + sent);
                if (sent == dis_at) cfg_enable = 1'b0;
                if (sent == len_at) cfg_length = 16'(nlen);
            end
            guard++;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_out;
        int g;
        g = 0;
        m_if.tready = 1'b1;
        while (obs_q.size() < exp_q.size() && g < 2000) begin
            @(posedge aclk);
            g++;
        end
        repeat (4) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, sts_packets} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%0h want=0",
                     {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, sts_packets});
        end
    endtask

    task automatic test_basic;
        int sent;
        logic [32:0] e, o;
        do_reset;
        for (int i = 0; i < 8; i++) exp_q.push_back({i % 4 == 3, 32'(i)});
        enable(4);
        stream(8, 0, 1'b0, -1, -1, 0, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd2) begin
            bad++;
            $display("FAIL basic_packets got=%0d want=2", sts_packets);
        end
        total++;
        if (first_vld - first_acc !== 1) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=1", first_vld - first_acc);
        end
    endtask

    task automatic test_len_zero;
        int sent;
        logic [32:0] e, o;
        do_reset;
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 32'(50 + i)});
        enable(0);
        stream(6, 50, 1'b0, -1, -1, 0, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL len0_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL len0_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd6) begin
            bad++;
            $display("FAIL len0_packets got=%0d want=6", sts_packets);
        end
    endtask

    task automatic test_disable_mid;
        int sent;
        logic [32:0] e, o;
        do_reset;
        for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 32'(20 + i)});
        enable(5);
        stream(5, 20, 1'b0, 3, -1, 0, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL dis_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dis_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd1) begin
            bad++;
            $display("FAIL dis_packets got=%0d want=1", sts_packets);
        end
        total++;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
        if (s_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL dis_ready got=%0b want=1", s_if.tready);
        end
`else
        if (s_if.tready !== 1'b0) begin
            bad++;
            $display("FAIL dis_ready got=%0b want=0", s_if.tready);
        end
`endif
    endtask

    task automatic test_backpressure;
        int sent;
        logic [32:0] e, o;
        do_reset;
        for (int i = 0; i < 999; i++) exp_q.push_back({i % 3 == 2, 32'(1000 + i)});
        enable(3);
        stream(999, 1000, 1'b1, -1, -1, 0, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL bp_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd333) begin
            bad++;
            $display("FAIL bp_packets got=%0d want=333", sts_packets);
        end
        total++;
        if (stab_err !== 0) begin
            bad++;
            $display("FAIL bp_stable got=%0d want=0", stab_err);
        end
    endtask

    task automatic test_len_change;
        int sent;
        logic [32:0] e, o;
        do_reset;
        for (int i = 0; i < 8; i++)
            exp_q.push_back({i == 3 || i == 5 || i == 7, 32'(300 + i)});
        enable(4);
        stream(8, 300, 1'b0, -1, 1, 2, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL lenchg_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL lenchg_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd3) begin
            bad++;
            $display("FAIL lenchg_packets got=%0d want=3", sts_packets);
        end
    endtask

    task automatic test_reset_mid;
        int sent;
        logic [32:0] e, o;
        do_reset;
        enable(4);
        m_if.tready = 1'b0;
        stream(2, 7, 1'b0, -1, -1, 0, sent);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, sts_packets} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs got=%0h want=0",
                     {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, sts_packets});
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cfg_enable = 1'b0;
        m_if.tready = 1'b1;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'(100 + i)});
        enable(4);
        stream(4, 100, 1'b0, -1, -1, 0, sent);
        wait_out;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rstmid_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstmid_beat got=%0h want=%0h", o, e);
            end
        end
        total++;
        if (sts_packets !== 32'd1) begin
            bad++;
            $display("FAIL rstmid_packets got=%0d want=1", sts_packets);
        end
    endtask

    task automatic test_idle;
        int acc;
        do_reset;
        acc = 0;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.tdata = 32'(900 + i);
            @(negedge aclk);
            if (s_if.tready) acc++;
            @(posedge aclk);
            #1;
        end
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
        if (acc !== 10) begin
            bad++;
            $display("FAIL idle_accepts got=%0d want=10", acc);
        end
        total++;
        if (sts_dropped !== 32'd10) begin
            bad++;
            $display("FAIL idle_dropped got=%0d want=10", sts_dropped);
        end
`else
        if (acc !== 0) begin
            bad++;
            $display("FAIL idle_accepts got=%0d want=0", acc);
        end
`endif
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("FAIL idle_output got=%0d want=0", obs_q.size());
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        test_reset;
        test_basic;
        test_len_zero;
        test_disable_mid;
        test_backpressure;
        test_len_change;
        test_reset_mid;
        test_idle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
